imm_decode_ctrl: RTL and testbench

IMM_DECODE_CTRL -- requirements
Module: imm_decode_ctrl

---
 rtl/imm_decode_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_imm_decode_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_ctrl.sv
// ----------------------------------------------------------------------------
// imm_decode_ctrl
//   Classifies each fetched RV32 instruction by opcode, picks the matching
//   immediate returned by the external Imm_Gen, and queues {instr, imm, type,
//   illegal} in a 2-entry in-order buffer toward execute.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   flush_i                drop every buffered entry (and any same-cycle push)
//   in_valid_i/in_ready_o  fetch-side handshake, in_instr_i the raw word
//   gen_instr_o            combinational copy of in_instr_i for Imm_Gen
//   imm_*_type_i           immediates computed by Imm_Gen for gen_instr_o
//   out_valid_o/out_ready_i execute-side handshake
//   out_instr_o, out_imm_o, out_imm_type_o, out_illegal_o  head entry
//
// Configuration
//   IMM_DECODE_CTRL_ZIMM_EN  defined: CSR-immediate SYSTEM ops (funct3 101,
//                            110, 111) select zimm_rs1_type_i, type Z.
//                            undefined: every SYSTEM op selects the I-imm.
// ----------------------------------------------------------------------------
module imm_decode_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_instr_i,
    output logic [31:0] gen_instr_o,
    input  logic [31:0] imm_i_type_i,
    input  logic [31:0] imm_s_type_i,
    input  logic [31:0] imm_b_type_i,
    input  logic [31:0] imm_u_type_i,
    input  logic [31:0] imm_j_type_i,
    input  logic [31:0] zimm_rs1_type_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_imm_o,
    output logic [2:0]  out_imm_type_o,
    output logic        out_illegal_o
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned TYPE_W  = 3;

    localparam logic [TYPE_W-1:0] T_NONE = 3'd0;
    localparam logic [TYPE_W-1:0] T_I    = 3'd1;
    localparam logic [TYPE_W-1:0] T_S    = 3'd2;
    localparam logic [TYPE_W-1:0] T_B    = 3'd3;
    localparam logic [TYPE_W-1:0] T_U    = 3'd4;
    localparam logic [TYPE_W-1:0] T_J    = 3'd5;
`ifdef IMM_DECODE_CTRL_ZIMM_EN
    localparam logic [TYPE_W-1:0] T_Z    = 3'd6;
`endif

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] imm;
        logic [TYPE_W-1:0]  typ;
        logic               illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;

    logic [INSTR_W-1:0] dec_imm;
    logic [TYPE_W-1:0]  dec_type;
    logic               dec_illegal;
    entry_t             new_entry;
    logic               push, pop;

    assign gen_instr_o = in_instr_i;

`ifndef IMM_DECODE_CTRL_ZIMM_EN
    logic unused_zimm;
    assign unused_zimm = ^zimm_rs1_type_i;
`endif

    // Opcode classification and immediate selection for the offered word
    always_comb begin
        dec_imm     = '0;
        dec_type    = T_NONE;
        dec_illegal = 1'b0;
        unique case (in_instr_i[6:0])
            7'b0110111, 7'b0010111: begin
                dec_imm  = imm_u_type_i;
                dec_type = T_U;
            end
            7'b1101111: begin
                dec_imm  = imm_j_type_i;
                dec_type = T_J;
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: begin
                dec_imm  = imm_i_type_i;
                dec_type = T_I;
            end
            7'b1100011: begin
                dec_imm  = imm_b_type_i;
                dec_type = T_B;
            end
            7'b0100011: begin
                dec_imm  = imm_s_type_i;
                dec_type = T_S;
            end
            7'b0110011: begin
                dec_imm  = '0;
                dec_type = T_NONE;
            end
            7'b1110011: begin
`ifdef IMM_DECODE_CTRL_ZIMM_EN
                // funct3 101/110/111 are the CSR*I forms carrying uimm in rs1
                if (in_instr_i[14] && (in_instr_i[13:12] != 2'b00)) begin
                    dec_imm  = zimm_rs1_type_i;
                    dec_type = T_Z;
                end else begin
                    dec_imm  = imm_i_type_i;
                    dec_type = T_I;
                end
`else
                dec_imm  = imm_i_type_i;
                dec_type = T_I;
`endif
            end
            default: begin
                dec_imm     = '0;
                dec_type    = T_NONE;
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign new_entry = '{instr: in_instr_i, imm: dec_imm, typ: dec_type, illegal: dec_illegal};

    assign push = in_valid_i & in_ready_q;
    assign pop  = out_valid_q & out_ready_i;

    // Occupancy FSM; the head slot is cleared whenever the buffer goes empty
    // so a stale entry can never be observed with out_valid_o low.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            head_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        head_d  = new_entry;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_d = new_entry;
                    end else if (push) begin
                        state_d = ST_TWO;
                        tail_d  = new_entry;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                        head_d  = '0;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        head_d  = tail_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    head_d  = '0;
                end
            endcase
        end
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Second slot is only read after being written, so it carries no reset
    always_ff @(posedge clk_i) begin
        tail_q <= tail_d;
    end

    assign in_ready_o     = in_ready_q;
    assign out_valid_o    = out_valid_q;
    assign out_instr_o    = head_q.instr;
    assign out_imm_o      = head_q.imm;
    assign out_imm_type_o = head_q.typ;
    assign out_illegal_o  = head_q.illegal;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// ----------------------------------------------------------------------------
// tb_imm_decode_ctrl
//   Directed and randomized bench for imm_decode_ctrl. Imm_Gen is modelled
//   from the RV32 immediate formats; expected outputs come from a queue-based
//   reference of the 2-deep buffer and a table-driven opcode classifier.
//   Honours IMM_DECODE_CTRL_ZIMM_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_imm_decode_ctrl;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] gen_instr;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_imm;
    logic [2:0]  out_type;
    logic        out_illegal;

    int   total  = 0;
    int   passes = 0;
    exp_t q[$];
    bit   checks_on = 0;
    bit   fresh_reset = 0;

    always #5 clk = ~clk;

    // Imm_Gen stand-in, driven from the bench's own copy of the instruction
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_z = {27'b0, instr[19:15]};

    imm_decode_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_instr_i     (instr),
        .gen_instr_o    (gen_instr),
        .imm_i_type_i   (imm_i),
        .imm_s_type_i   (imm_s),
        .imm_b_type_i   (imm_b),
        .imm_u_type_i   (imm_u),
        .imm_j_type_i   (imm_j),
        .zimm_rs1_type_i(imm_z),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_instr_o    (out_instr),
        .out_imm_o      (out_imm),
        .out_imm_type_o (out_type),
        .out_illegal_o  (out_illegal)
    );

    function automatic exp_t classify(input logic [31:0] x);
        exp_t e;
        logic [2:0] f3;
        f3 = x[14:12];
        e.instr = x;
        e.illegal = 1'b0;
        case (x[6:0])
            7'h37, 7'h17: begin e.typ = 3'd4; e.imm = {x[31:12], 12'b0}; end
            7'h6F: begin e.typ = 3'd5; e.imm = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0}; end
            7'h67, 7'h03, 7'h13, 7'h0F: begin e.typ = 3'd1; e.imm = {{20{x[31]}}, x[31:20]}; end
            7'h63: begin e.typ = 3'd3; e.imm = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0}; end
            7'h23: begin e.typ = 3'd2; e.imm = {{20{x[31]}}, x[31:25], x[11:7]}; end
            7'h33: begin e.typ = 3'd0; e.imm = 32'd0; end
            7'h73: begin
`ifdef IMM_DECODE_CTRL_ZIMM_EN
                if (f3 == 3'd5 || f3 == 3'd6 || f3 == 3'd7) begin
                    e.typ = 3'd6; e.imm = {27'b0, x[19:15]};
                end else begin
                    e.typ = 3'd1; e.imm = {{20{x[31]}}, x[31:20]};
                end
`else
                e.typ = 3'd1; e.imm = {{20{x[31]}}, x[31:20]};
`endif
            end
            default: begin e.typ = 3'd0; e.imm = 32'd0; e.illegal = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) begin
            passes++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle, compare outputs against the model, then advance both
    task automatic step(input logic v, input logic [31:0] ins, input logic r,
                        input logic f, input logic rn);
        bit do_push, do_pop;
        in_valid = v; instr = ins; out_ready = r; flush = f; rst_n = rn;
        #1;
        if (checks_on) begin
            chk("gen_instr", gen_instr, ins);
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("head_instr", out_instr, q[0].instr);
                chk("head_imm", out_imm, q[0].imm);
                chk("head_type", 32'(out_type), 32'(q[0].typ));
                chk("head_illegal", 32'(out_illegal), 32'(q[0].illegal));
            end else if (fresh_reset) begin
                chk("rst_instr", out_instr, 32'd0);
                chk("rst_imm", out_imm, 32'd0);
                chk("rst_type", 32'(out_type), 32'd0);
                chk("rst_illegal", 32'(out_illegal), 32'd0);
            end
        end
        @(posedge clk);
        do_push = v && (q.size() < 2);
        do_pop  = r && (q.size() > 0);
        if (!rn) begin
            q.delete();
            checks_on = 1;
            fresh_reset = 1;
        end else if (f) begin
            q.delete();
            fresh_reset = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(classify(ins));
                fresh_reset = 0;
            end
        end
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] imm_v,
                               input logic [2:0] typ_v, input logic ill_v);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_imm"}, out_imm, imm_v);
        chk({tag, "_type"}, 32'(out_type), 32'(typ_v));
        chk({tag, "_illegal"}, 32'(out_illegal), 32'(ill_v));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                                  7'h0F, 7'h63, 7'h23, 7'h33, 7'h73};
        logic [31:0] w;
        int unsigned k;
        w = $urandom();
        k = $urandom_range(0, 11);
        if (k < 11) w[6:0] = ops[k];
        return w;
    endfunction

    initial begin
        in_valid = 0; instr = 0; out_ready = 0; flush = 0; rst_n = 0;

        // Reset, then idle with reset values visible
        step(0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 1);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);

        // addi x1,x0,5: one-cycle latency from EMPTY
        step(1, 32'h00500093, 1, 0, 1);
        expect_head("addi", 32'h00000005, 3'd1, 1'b0);
        // beq -4 replaces head while the addi pops
        step(1, 32'hFE000EE3, 1, 0, 1);
        expect_head("beq", 32'hFFFFFFFC, 3'd3, 1'b0);
        // csrrwi
        step(1, 32'h300FD073, 1, 0, 1);
`ifdef IMM_DECODE_CTRL_ZIMM_EN
        expect_head("csrwi", 32'h0000001F, 3'd6, 1'b0);
`else
        expect_head("csrwi", 32'h00000300, 3'd1, 1'b0);
`endif
        step(0, 32'h0, 1, 0, 1);
        chk("drained_valid", 32'(out_valid), 32'd0);

        // Back-pressure: A, B fill the buffer, C is held off
        step(1, 32'h00100113, 0, 0, 1);
        step(1, 32'h00200193, 0, 0, 1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step(1, 32'h00300213, 0, 0, 1);
        step(1, 32'h00300213, 0, 0, 1);
        step(1, 32'h00300213, 1, 0, 1);
        step(0, 32'h0, 1, 0, 1);
        step(0, 32'h0, 1, 0, 1);
        step(0, 32'h0, 1, 0, 1);

        // Flush in ONE with a simultaneous push
        step(1, 32'h00000093, 0, 0, 1);
        step(1, 32'h00000013, 0, 1, 1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        step(0, 32'h0, 1, 0, 1);

        // Unsupported opcode
        step(1, 32'h0000007F, 0, 0, 1);
        expect_head("illegal", 32'h0, 3'd0, 1'b1);

        // Reset from TWO
        step(1, 32'h12345037, 0, 0, 1);
        chk("two_in_ready", 32'(in_ready), 32'd0);
        step(1, 32'h0000006F, 1, 1, 0);
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_instr", out_instr, 32'd0);
        chk("rst2_ready", 32'(in_ready), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 3) != 0), rand_instr(),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 99) != 0));
        end
        step(0, 32'h0, 1, 0, 1);
        step(0, 32'h0, 1, 0, 1);
        step(0, 32'h0, 1, 0, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
